// File: rtl/seq_detect_pkg.sv
// Shared state encoding for the parametrised serial sequence detector.
package seq_detect_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_e;

endpackage : seq_detect_pkg

// File: rtl/seq_hist_shreg.sv
// History shift register (newest bit at LSB) with a saturating fill counter.
// Exposes the post-shift history and "full after this bit" for same-cycle compare.
module seq_hist_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             w,
  output logic [PAT_W-1:0] hist_next,
  output logic             full_next
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_next;
  logic [FILL_W-1:0] fill_d;

  always_comb begin
    hist_next = hist_q;
    fill_next = fill_q;
    if (shift) begin
      hist_next = {hist_q[PAT_W-2:0], w};
      if (fill_q != FILL_MAX) begin
        fill_next = fill_q + 1'b1;
      end
    end
    full_next = (fill_next == FILL_MAX);
    // Clear wins over the shift so a restart never keeps the offered bit.
    hist_d = clr ? '0 : hist_next;
    fill_d = clr ? '0 : fill_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule : seq_hist_shreg

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with registered one-cycle match pulse z.
// Optional saturating match counter port match_cnt under `define SEQ_MATCH_CNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(4'b1010),
  parameter int               OVERLAP     = 1,
  parameter int               CNT_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               w_valid,
  input  logic               w,
  input  logic               pat_load,
  input  logic [PAT_W-1:0]   pat_in,
  output logic               z,
  output logic [STATE_W-1:0] present_state
`ifdef SEQ_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             z_q, z_d;
  logic             active;
  logic             accept;
  logic             match;
  logic             restart;
  logic             clr;
  logic [PAT_W-1:0] hist_next;
  logic             full_next;

  // A bit only counts while detecting and enabled; en==0 drops the offered bit.
  assign active  = (state_q == FILL) || (state_q == RUN);
  assign accept  = active && en && w_valid;
  assign match   = accept && full_next && (hist_next == pat_q);
  assign restart = match && (OVERLAP == 0);
  assign clr     = !active || !en || restart;

  seq_hist_shreg #(
    .PAT_W(PAT_W)
  ) u_hist (
    .clock    (clock),
    .reset    (reset),
    .clr      (clr),
    .shift    (accept),
    .w        (w),
    .hist_next(hist_next),
    .full_next(full_next)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    z_d     = match;
    case (state_q)
      IDLE: begin
        if (pat_load) pat_d = pat_in;
        if (en) state_d = FILL;
      end
      FILL: begin
        if (!en) state_d = IDLE;
        else if (restart) state_d = FILL;
        else if (accept && full_next) state_d = RUN;
      end
      RUN: begin
        if (!en) state_d = IDLE;
        else if (restart) state_d = FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= PAT_DEFAULT;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      z_q     <= z_d;
    end
  end

  assign z             = z_q;
  assign present_state = state_q;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: overlapping, non-overlapping and PAT_W=2 instances.
// Inputs change on negedge; each step's expectations are queued, then popped #1 after posedge.
module tb_seq_detect_param;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SF = 2'b01;
  localparam logic [1:0] SR = 2'b10;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       w_valid;
  logic       w;
  logic       pat_load;
  logic [3:0] pat_in;

  logic       z_a, z_n, z_2;
  logic [1:0] st_a, st_n, st_2;
`ifdef SEQ_MATCH_CNT_EN
  logic [7:0] cnt_a, cnt_n;
  logic [1:0] cnt_2;
`endif

  logic [2:0] exp_q[$];
  logic [2:0] exp_nq[$];
  logic [4:0] exp_2q[$];

  int  checks = 0;
  int  errors = 0;
  bit  chk_a  = 1'b0;
  bit  chk_n  = 1'b0;
  bit  chk_2  = 1'b0;

  always #5 clock = ~clock;

  seq_detect_param #(.PAT_W(4), .PAT_DEFAULT(4'b1010), .OVERLAP(1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .en(en), .w_valid(w_valid), .w(w),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_a), .present_state(st_a)
`ifdef SEQ_MATCH_CNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  seq_detect_param #(.PAT_W(4), .PAT_DEFAULT(4'b1010), .OVERLAP(0), .CNT_W(8)) dut_n (
    .clock(clock), .reset(reset), .en(en), .w_valid(w_valid), .w(w),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_n), .present_state(st_n)
`ifdef SEQ_MATCH_CNT_EN
    , .match_cnt(cnt_n)
`endif
  );

  seq_detect_param #(.PAT_W(2), .PAT_DEFAULT(2'b11), .OVERLAP(1), .CNT_W(2)) dut_2 (
    .clock(clock), .reset(reset), .en(en), .w_valid(w_valid), .w(w),
    .pat_load(1'b0), .pat_in(2'b00), .z(z_2), .present_state(st_2)
`ifdef SEQ_MATCH_CNT_EN
    , .match_cnt(cnt_2)
`endif
  );

  // ea/en_e = {z, state}; e2 = {match_cnt[1:0], z, state}.
  task automatic step(input logic rst_i, input logic en_i, input logic wv_i, input logic w_i,
                      input logic pl_i, input logic [3:0] pi_i,
                      input logic [2:0] ea, input logic [2:0] en_e, input logic [4:0] e2,
                      input string tag);
    logic [2:0] xa, xn;
    logic [4:0] x2;
    @(negedge clock);
    reset = rst_i; en = en_i; w_valid = wv_i; w = w_i; pat_load = pl_i; pat_in = pi_i;
    if (chk_a) exp_q.push_back(ea);
    if (chk_n) exp_nq.push_back(en_e);
    if (chk_2) exp_2q.push_back(e2);
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      xa = exp_q.pop_front();
      checks++;
      assert ({z_a, st_a} === xa) else begin
        errors++;
        $error("FAIL %s ovl z/state observed=%b required=%b", tag, {z_a, st_a}, xa);
      end
    end
    if (exp_nq.size() > 0) begin
      xn = exp_nq.pop_front();
      checks++;
      assert ({z_n, st_n} === xn) else begin
        errors++;
        $error("FAIL %s novl z/state observed=%b required=%b", tag, {z_n, st_n}, xn);
      end
    end
    if (exp_2q.size() > 0) begin
      x2 = exp_2q.pop_front();
      checks++;
`ifdef SEQ_MATCH_CNT_EN
      assert ({cnt_2, z_2, st_2} === x2) else begin
        errors++;
        $error("FAIL %s w2 cnt/z/state observed=%b required=%b", tag, {cnt_2, z_2, st_2}, x2);
      end
`else
      assert ({z_2, st_2} === x2[2:0]) else begin
        errors++;
        $error("FAIL %s w2 z/state observed=%b required=%b", tag, {z_2, st_2}, x2[2:0]);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; w_valid = 1'b0; w = 1'b0; pat_load = 1'b0; pat_in = 4'h0;

    // Reset state, then overlapping vs non-overlapping on 10101010.
    chk_a = 1'b1; chk_n = 1'b1;
    step(0, 0, 0, 0, 0, 4'h0, {1'b0, SI}, {1'b0, SI}, 5'h0, "reset");
    step(1, 0, 1, 1, 0, 4'h0, {1'b0, SI}, {1'b0, SI}, 5'h0, "idle_ignore");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "enable");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t1_b1");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t1_b2");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t1_b3");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, {1'b1, SF}, 5'h0, "t1_b4");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, {1'b0, SF}, 5'h0, "t1_b5");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, {1'b0, SF}, 5'h0, "t1_b6");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, {1'b0, SF}, 5'h0, "t2_b7");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, {1'b1, SF}, 5'h0, "t2_b8");

    // Gapped stream: w toggles while w_valid is low and must be ignored.
    step(1, 0, 1, 1, 0, 4'h0, {1'b0, SI}, {1'b0, SI}, 5'h0, "t3_disable");
    step(1, 1, 0, 0, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_enable");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_v1");
    step(1, 1, 0, 0, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_g1");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_v2");
    step(1, 1, 0, 1, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_g2");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_v3");
    step(1, 1, 0, 0, 0, 4'h0, {1'b0, SF}, {1'b0, SF}, 5'h0, "t3_g3");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, {1'b1, SF}, 5'h0, "t3_v4");
    step(1, 1, 0, 1, 0, 4'h0, {1'b0, SR}, {1'b0, SF}, 5'h0, "t3_g4");

    // pat_load in RUN is ignored; 1100 does not match, 1010 still does.
    chk_n = 1'b0;
    step(1, 1, 0, 0, 1, 4'hC, {1'b0, SR}, 3'b0, 5'h0, "t4_load_run");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_a1");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_a2");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_a3");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_a4_nomatch");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_b1");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_b2");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t4_b3");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, 3'b0, 5'h0, "t4_b4_old");
    // Load in IDLE, then 1100 matches.
    step(1, 0, 1, 0, 0, 4'h0, {1'b0, SI}, 3'b0, 5'h0, "t4_disable");
    step(1, 0, 0, 0, 1, 4'hC, {1'b0, SI}, 3'b0, 5'h0, "t4_load_idle");
    step(1, 1, 0, 0, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t4_enable");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t4_c1");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t4_c2");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t4_c3");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, 3'b0, 5'h0, "t4_c4_new");

    // Mid-stream reset restores IDLE and the default pattern.
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t5_b1");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t5_b2");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SR}, 3'b0, 5'h0, "t5_b3");
    step(0, 1, 1, 0, 0, 4'h0, {1'b0, SI}, 3'b0, 5'h0, "t5_reset");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t5_b4_idle");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t5_d1");
    step(1, 1, 1, 0, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t5_d2");
    step(1, 1, 1, 1, 0, 4'h0, {1'b0, SF}, 3'b0, 5'h0, "t5_d3");
    step(1, 1, 1, 0, 0, 4'h0, {1'b1, SR}, 3'b0, 5'h0, "t5_d4_default");

    // PAT_W=2, pattern 11, ten 1s: z every cycle from bit 2, count saturates at 3.
    chk_a = 1'b0; chk_2 = 1'b1;
    step(0, 0, 0, 0, 0, 4'h0, 3'b0, 3'b0, {2'd0, 1'b0, SI}, "t6_reset");
    step(1, 1, 1, 1, 0, 4'h0, 3'b0, 3'b0, {2'd0, 1'b0, SF}, "t6_enable");
    step(1, 1, 1, 1, 0, 4'h0, 3'b0, 3'b0, {2'd0, 1'b0, SF}, "t6_b1");
    step(1, 1, 1, 1, 0, 4'h0, 3'b0, 3'b0, {2'd1, 1'b1, SR}, "t6_b2");
    step(1, 1, 1, 1, 0, 4'h0, 3'b0, 3'b0, {2'd2, 1'b1, SR}, "t6_b3");
    for (int i = 4; i <= 10; i++) begin
      step(1, 1, 1, 1, 0, 4'h0, 3'b0, 3'b0, {2'd3, 1'b1, SR}, $sformatf("t6_b%0d", i));
    end
    step(1, 1, 0, 1, 0, 4'h0, 3'b0, 3'b0, {2'd3, 1'b0, SR}, "t6_gap");
    step(1, 0, 1, 1, 0, 4'h0, 3'b0, 3'b0, {2'd3, 1'b0, SI}, "t6_disable_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_detect_param

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 4-state Mealy "1010" detector used in lab FSM blocks.
- Detects a runtime-loadable PAT_W-bit pattern on a qualified serial input, in overlapping or non-overlapping mode.
- Produces a registered one-cycle match pulse and exposes its control-FSM state for debug.
- Sits between a serial bit source (w / w_valid) and any consumer of match events.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16)
PAT_DEFAULT, 4'b1010, pattern loaded at reset; width PAT_W
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match
CNT_W, 8, width of the match counter (optional feature only)

Ports:
clock  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-low reset
en  input  1  detector enable
w_valid  input  1  w is sampled only when this is 1
w  input  1  serial data bit
pat_load  input  1  load pat_in into the pattern register (honoured only in IDLE)
pat_in  input  PAT_W  new pattern, MSB = oldest bit
z  output  1  registered match pulse
present_state  output  2  current FSM state encoding
match_cnt  output  CNT_W  saturating match count (exists only with SEQ_MATCH_CNT_EN)

Behaviour:
- Reset: sampled when reset==0 at posedge. Sets state=IDLE, hist=0, fill=0, z=0, pat=PAT_DEFAULT, match_cnt=0. Reset overrides every other input, including mid-stream.
- States (2'b encoding):
  - IDLE=00
  - FILL=01 (fewer than PAT_W valid bits held)
  - RUN=10 (history full)
  - 11 is unused; it must recover to IDLE on the next clock.
- History: on an accepted bit, hist_next = {hist[PAT_W-2:0], w}. Newest bit at LSB. fill saturates at PAT_W.
- A bit is accepted when state is FILL or RUN and w_valid==1. w_valid is ignored in IDLE.
- IDLE:
  - en==1 -> FILL next cycle, with fill=0 and hist=0.
  - pat_load==1 -> pat<=pat_in. If en and pat_load are both 1 in the same cycle, the load happens and the state goes to FILL; the new pattern applies to all following bits.
- FILL:
  - An accepted bit increments fill.
  - When the accepted bit makes fill reach PAT_W, go to RUN.
- RUN: stays in RUN while en==1.
- en==0 in FILL or RUN -> IDLE next cycle; hist and fill clear. A bit offered in that same cycle is ignored.
- pat_load outside IDLE is ignored; pat does not change.
- Match condition: accepted bit AND (fill==PAT_W-1 or state==RUN) AND hist_next==pat.
- z timing: z<=1 at the clock edge that samples the completing bit, so z is high for exactly the following cycle; otherwise z<=0.
- Latency: 1 cycle from the completing bit's sample edge to z high.
- Back-to-back matches in consecutive cycles are legal when OVERLAP=1 (e.g. pattern 1111 with a run of 1s).
- OVERLAP=0: on a match, hist<=0, fill<=0, state<=FILL. The completing bit is not reused.
- z never asserts in IDLE or while reset==0.

Optional Feature:
- Macro: SEQ_MATCH_CNT_EN.
- Defined:
  - Port match_cnt exists.
  - It increments on each cycle in which the match condition is true and saturates at 2^CNT_W-1.
  - It clears only on reset, not on en toggling.
- Undefined: no match_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Package seq_detect_pkg: state enum/localparams (IDLE, FILL, RUN) and the 2-bit state width constant.
- One natural sub-module, seq_hist_shreg: the PAT_W-bit history shift register with fill counter. It outputs hist_next and full_next; the FSM, compare and counter stay in the top level.

Test Plan:
1. Default pattern 1010, OVERLAP=1, en=1, w_valid=1, bits 1,0,1,0,1,0 -> z high in the cycle after bit 4 and after bit 6; z low elsewhere; present_state 01 -> 10 after bit 4.
2. OVERLAP=0, bits 1,0,1,0,1,0,1,0 -> z after bit 4 and bit 8 only; state returns to 01 after bit 4.
3. Bits 1,0,1,0 with w_valid=0 inserted between every bit (held w toggling during gaps) -> exactly one z pulse, one cycle after the 4th valid bit.
4. In RUN, assert pat_load with pat_in=4'b1100, then stream 1,1,0,0 -> no change; z fires only for 1010. Then en=0, pat_load with 1100, en=1, stream 1,1,0,0 -> z after the 4th bit.
5. Stream 1,0,1, then reset=0 for 1 cycle, then 0 -> z stays 0; state IDLE after reset; pat back to 1010.
6. With SEQ_MATCH_CNT_EN and CNT_W=2, PAT_W=2, pattern 11, ten consecutive 1s -> 9 matches; match_cnt holds at 3; z pulses every cycle from bit 2.
